// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer_if
//  Purpose  : Request/response channel bundle for the ALU sequencer.
//             The master issues operations (req_*) and consumes held
//             responses (rsp_*). The slave is the sequencer itself.
//  Signals  : req_valid/req_ready  request handshake
//             req_op[3:0]          [2:0] ALU opcode, [3] multiply select
//             req_a/req_b          operands, WIDTH bits
//             rsp_valid/rsp_ready  response handshake, rsp_valid held
//             rsp_result           result, WIDTH bits
//             rsp_zero/rsp_ovf     result-is-zero and multiply overflow
//  Revision : 1.0  initial release
// ============================================================================
interface alu_sequencer_if #(
  parameter int WIDTH = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf
  );

endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Sequences an external 8-bit combinational ALU. Accepts one
//             operation per request handshake, registers operands/opcode
//             towards the ALU, captures Result/Zero one cycle later and
//             presents them on a held response channel.
//  Params   : WIDTH  operand/result width (must match the ALU)
//  Ports    : clk          system clock, rising edge
//             rst_n        asynchronous active-low reset
//             bus          alu_sequencer_if.slave (req_* / rsp_* channels)
//             alu_a/alu_b  registered operands to the ALU
//             alu_opcode   registered opcode to the ALU
//             alu_result   ALU Result
//             alu_zero     ALU Zero flag
//             busy         high whenever the controller is not idle
//  Options  : MUL_REPEAT_EN  when defined, req_op[3]=1 selects an unsigned
//             multiply performed as repeated ALU additions. When undefined
//             req_op[3] is ignored and rsp_ovf is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  wire                    clk,
  input  wire                    rst_n,
  alu_sequencer_if.slave         bus,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_opcode,
  input  wire  [WIDTH-1:0]       alu_result,
  input  wire                    alu_zero,
  output logic                   busy
);

`ifdef MUL_REPEAT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd3
  } state_t;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;

  state_t state;

`ifdef MUL_REPEAT_EN
  // Multiply datapath: acc mirrors alu_a, cnt counts remaining additions.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cnt;
  logic             ovf;
  // A sum smaller than the running accumulator means the ALU wrapped.
  logic             carry;
  assign carry = (alu_result < acc);
`else
  // Multiply select bit has no meaning in this build.
  logic unused_mul_sel;
  assign unused_mul_sel = bus.req_op[3];
  assign bus.rsp_ovf    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= OP_ADD;
      busy           <= 1'b0;
`ifdef MUL_REPEAT_EN
      bus.rsp_ovf    <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
`ifdef MUL_REPEAT_EN
            if (bus.req_op[3]) begin
              // A*B as B additions of A into an accumulator starting at 0.
              alu_a      <= '0;
              alu_b      <= bus.req_a;
              alu_opcode <= OP_ADD;
              acc        <= '0;
              cnt        <= bus.req_b;
              ovf        <= 1'b0;
              state      <= MUL;
            end else begin
              alu_a      <= bus.req_a;
              alu_b      <= bus.req_b;
              alu_opcode <= bus.req_op[2:0];
              state      <= EXEC;
            end
`else
            alu_a      <= bus.req_a;
            alu_b      <= bus.req_b;
            alu_opcode <= bus.req_op[2:0];
            state      <= EXEC;
`endif
          end
        end

        EXEC: begin
          // ALU inputs were registered last cycle; its output is settled now.
          bus.rsp_result <= alu_result;
          bus.rsp_zero   <= alu_zero;
`ifdef MUL_REPEAT_EN
          bus.rsp_ovf    <= 1'b0;
`endif
          bus.rsp_valid  <= 1'b1;
          state          <= RESP;
        end

`ifdef MUL_REPEAT_EN
        MUL: begin
          if (cnt == '0) begin
            // Only reachable with B=0: nothing was added, result is 0.
            bus.rsp_result <= acc;
            bus.rsp_zero   <= (acc == '0);
            bus.rsp_ovf    <= ovf;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            acc   <= alu_result;
            alu_a <= alu_result;
            cnt   <= cnt - WIDTH'(1);
            ovf   <= ovf | carry;
            if (cnt == WIDTH'(1)) begin
              // Last addition: publish the sum straight from the ALU so the
              // response does not wait an extra cycle.
              bus.rsp_result <= alu_result;
              bus.rsp_zero   <= (alu_result == '0);
              bus.rsp_ovf    <= ovf | carry;
              bus.rsp_valid  <= 1'b1;
              state          <= RESP;
            end
          end
        end
`endif

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
